// File: rtl/park_frame_rx.sv
// Pulse-width-coded parking-sensor receiver. It conditions the line, times the low and high
// phases in microsecond ticks, and publishes a 9-byte frame only when its checksum byte matches.
module park_frame_rx #(
  parameter int TICK_DIV = 48,
  parameter int BIT_MIN  = 50,
  parameter int BIT_THR  = 150,
  parameter int SYNC_MIN = 800,
  parameter int GAP_MAX  = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        park_in,
  output logic [71:0] park_frame,
  output logic        park_vld,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic [2:0]  dbg_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);
  localparam logic [11:0] BIT_MIN_W  = 12'(BIT_MIN);
  localparam logic [11:0] BIT_THR_W  = 12'(BIT_THR);
  localparam logic [11:0] SYNC_MIN_W = 12'(SYNC_MIN);
  localparam logic [11:0] GAP_MAX_W  = 12'(GAP_MAX);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC_LOW = 3'd1,
    S_GAP      = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_CHECK    = 3'd4
  } state_t;

  logic [1:0]    sync_q;
  logic [1:0]    hist_q;
  logic          line_q, line_prev_q;
  logic [TW-1:0] div_q;
  logic [11:0]   width_q;
  state_t        state_q, state_d;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [71:0]   sr_q, sr_d;
  logic [71:0]   park_frame_q, park_frame_d;
  logic          park_vld_q, park_vld_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q;

  logic          maj, tick, line_edge, fall, rise;
  logic [71:0]   rx_frame;
  logic [7:0]    csum;

  // Majority of the synchronized sample and its two predecessors rejects 1-clk spikes.
  assign maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign tick      = (div_q == DIV_LAST);
  assign line_edge = line_q ^ line_prev_q;
  assign fall      = line_prev_q & ~line_q;
  assign rise      = line_q & ~line_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      hist_q      <= 2'b11;
      line_q      <= 1'b1;
      line_prev_q <= 1'b1;
      div_q       <= '0;
      width_q     <= '0;
    end else begin
      sync_q      <= {sync_q[0], park_in};
      hist_q      <= {hist_q[0], sync_q[1]};
      line_q      <= maj;
      line_prev_q <= line_q;
      div_q       <= tick ? '0 : div_q + 1'b1;
      if (line_edge)
        width_q <= '0;
      else if (tick && width_q != 12'hFFF)
        width_q <= width_q + 12'd1;
    end
  end

  // Bytes arrive MSB first with byte 0 first, so the shift register holds byte 0 at its top.
  always_comb begin
    rx_frame = '0;
    for (int k = 0; k < 9; k++)
      rx_frame[8*k +: 8] = sr_q[8*(8-k) +: 8];
    csum = 8'hA5;
    for (int k = 0; k < 8; k++)
      csum = csum ^ rx_frame[8*k +: 8];
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    park_frame_d = park_frame_q;
    park_vld_d   = park_vld_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_SYNC_LOW;
      end
      S_SYNC_LOW: begin
        if (rise) begin
          if (width_q >= SYNC_MIN_W) begin
            state_d   = S_GAP;
            bit_cnt_d = '0;
            sr_d      = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (fall) begin
          state_d = S_BIT_LOW;
        end else if (width_q >= GAP_MAX_W) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_BIT_LOW: begin
        if (rise) begin
          if (width_q < BIT_MIN_W) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else if (width_q >= SYNC_MIN_W) begin
            // A sync-length pulse mid-frame restarts reception without leaving the frame.
            frame_err_d = 1'b1;
            state_d     = S_GAP;
            bit_cnt_d   = '0;
            sr_d        = '0;
          end else begin
            sr_d      = {sr_q[70:0], (width_q >= BIT_THR_W)};
            bit_cnt_d = bit_cnt_q + 7'd1;
            state_d   = (bit_cnt_q == 7'd71) ? S_CHECK : S_GAP;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (rx_frame[71:64] == csum) begin
          park_frame_d = rx_frame;
          park_vld_d   = 1'b1;
          frame_ok_d   = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      park_frame_q <= '0;
      park_vld_q   <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      park_frame_q <= park_frame_d;
      park_vld_q   <= park_vld_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      if (frame_err_d && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign park_frame = park_frame_q;
  assign park_vld   = park_vld_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_park_frame_rx.sv
// Bench for park_frame_rx with timing parameters scaled down so whole frames fit a short run.
// Expected frame_ok/frame_err events are queued by the stimulus and matched by a monitor.
module tb_park_frame_rx;

  localparam int TD   = 2;
  localparam int BMIN = 4;
  localparam int BTHR = 8;
  localparam int SMIN = 20;
  localparam int GMAX = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        park_in = 1'b1;
  logic [71:0] park_frame;
  logic        park_vld, frame_ok, frame_err;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  park_frame_rx #(
    .TICK_DIV(TD), .BIT_MIN(BMIN), .BIT_THR(BTHR), .SYNC_MIN(SMIN), .GAP_MAX(GMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .park_in(park_in),
    .park_frame(park_frame), .park_vld(park_vld), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // {frame_ok, frame_err, park_vld, err_cnt, park_frame}
  logic [82:0] exp_q[$];
  logic [71:0] exp_frame = '0;
  logic        exp_vld = 1'b0;
  logic [7:0]  exp_cnt = '0;

  localparam logic [71:0] GOOD1 = 72'hAD_08_07_06_05_04_03_02_01;
  localparam logic [71:0] BAD1  = 72'h00_08_07_06_05_04_03_02_01;
  localparam logic [71:0] GOOD2 = 72'h2D_88_77_66_55_44_33_22_11;
  localparam logic [71:0] GOOD3 = 72'hA5_FF_00_FF_00_FF_00_FF_00;

  task automatic check(input string name, input logic [82:0] act, input logic [82:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_ok(input logic [71:0] f);
    exp_frame = f;
    exp_vld   = 1'b1;
    exp_q.push_back({2'b10, exp_vld, exp_cnt, exp_frame});
  endtask

  task automatic push_err();
    exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    exp_q.push_back({2'b01, exp_vld, exp_cnt, exp_frame});
  endtask

  // driver tasks
  task automatic wait_ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  task automatic pulse(input int lo, input int hi);
    park_in = 1'b0;
    wait_ticks(lo);
    park_in = 1'b1;
    wait_ticks(hi);
  endtask

  task automatic send_sync();
    pulse(25, 6);
  endtask

  task automatic send_bit(input logic b);
    pulse(b ? 12 : 6, 6);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_bytes(input logic [71:0] f);
    for (int k = 0; k < 9; k++) send_byte(f[8*k +: 8]);
  endtask

  task automatic send_frame(input logic [71:0] f);
    send_sync();
    send_bytes(f);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (frame_ok || frame_err)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_event: ok=%0b err=%0b err_cnt=%0d with nothing expected",
                 frame_ok, frame_err, err_cnt);
      end else begin
        check("event", {frame_ok, frame_err, park_vld, err_cnt, park_frame}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_outputs", {park_frame, park_vld, frame_ok, frame_err, err_cnt}, 83'd0);
    check("reset_state", 83'(dbg_state), 83'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1-clk spike is filtered; a 3-clk dip reaches SYNC_LOW but is too short to sync
    park_in = 1'b0;
    @(negedge clk);
    park_in = 1'b1;
    repeat (20) @(negedge clk);
    check("spike_state", 83'(dbg_state), 83'd0);
    park_in = 1'b0;
    repeat (3) @(negedge clk);
    park_in = 1'b1;
    repeat (20) @(negedge clk);
    check("dip_state", 83'(dbg_state), 83'd0);
    check("dip_err_cnt", 83'(err_cnt), 83'd0);

    push_ok(GOOD1);
    send_frame(GOOD1);
    wait_ticks(10);
    check("good1_frame", 83'(park_frame), 83'(GOOD1));

    push_err();
    send_frame(BAD1);
    wait_ticks(10);
    check("badcs_keeps_frame", 83'(park_frame), 83'(GOOD1));
    check("badcs_vld", 83'(park_vld), 83'd1);

    // gap timeout after a 30-bit prefix
    push_err();
    send_sync();
    for (int i = 0; i < 30; i++) send_bit(GOOD2[8*(i/8) + 7 - (i%8)]);
    wait_ticks(30);
    check("gap_abort_state", 83'(dbg_state), 83'd0);
    push_ok(GOOD2);
    send_frame(GOOD2);
    wait_ticks(10);

    // runt low pulse mid-frame
    push_err();
    send_sync();
    send_byte(8'h5A);
    pulse(2, 6);
    check("glitch_abort_state", 83'(dbg_state), 83'd0);
    wait_ticks(10);

    // sync-length pulse mid-frame, then a frame without leading sync
    push_err();
    push_ok(GOOD3);
    send_sync();
    for (int k = 0; k < 5; k++) send_byte(GOOD1[8*k +: 8]);
    pulse(24, 6);
    send_bytes(GOOD3);
    wait_ticks(10);
    check("resync_frame", 83'(park_frame), 83'(GOOD3));

    for (int n = 0; n < 300; n++) begin
      push_err();
      send_sync();
      pulse(2, 6);
    end
    wait_ticks(10);
    check("err_cnt_saturated", 83'(err_cnt), 83'd255);
    check("drain", 83'(exp_q.size()), 83'd0);

    // asynchronous reset in the middle of a frame
    send_sync();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {park_frame, park_vld, frame_ok, frame_err, err_cnt}, 83'd0);
    check("async_reset_state", 83'(dbg_state), 83'd0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/park_frame_rx.md
Name: park_frame_rx

Overview:
- Decodes the single-wire pulse-width-coded parking-sensor stream on park_in into a checked 9-byte frame.
- Sits directly upstream of the MCU memory window that exposes the 9 park bytes at addresses 2048..2056.
- Only frames that pass the checksum update the output bytes.
- Counts malformed frames for diagnostics.

Parameters:
- TICK_DIV, 48, system clocks per 1 us decode tick (48 MHz clk).
- BIT_MIN, 50, minimum valid low-pulse width in ticks; shorter is a glitch.
- BIT_THR, 150, low width at or above this decodes as 1; below it (and at or above BIT_MIN) decodes as 0.
- SYNC_MIN, 800, low width at or above this is a frame sync.
- GAP_MAX, 500, maximum high time in ticks between pulses inside a frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- park_in  in  1  raw sensor line; idles high, active low
- park_frame  out  72  last good frame; byte k at [8k+7:8k], k=0..8
- park_vld  out  1  sticky; set on first good frame
- frame_ok  out  1  one-clk pulse when park_frame is updated
- frame_err  out  1  one-clk pulse on any frame abort
- err_cnt  out  8  saturating count of frame_err pulses

Behaviour:
- Reset state: asynchronous, active low. All outputs are 0 and the FSM is in IDLE. The synchronizer flops reset to 1 (line idle).
- Input conditioning: park_in passes through a 2-flop synchronizer, then a 3-sample majority filter on clk. The filtered level is "line". Edge latency from pin to line is 4 clk.
- Tick prescaler: counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1. It is free-running.
- Width counter: 12 bits. Cleared on every line edge. Increments on tick. Saturates at 4095, never wraps.
- States:
  - IDLE: line high. A falling edge goes to SYNC_LOW.
  - SYNC_LOW: on the rising edge, width >= SYNC_MIN goes to GAP with bit_cnt=0 and the shift register cleared. Any shorter width goes back to IDLE with no error (noise before sync).
  - GAP: line high. A falling edge goes to BIT_LOW. If width reaches GAP_MAX, abort.
  - BIT_LOW: on the rising edge, classify the width:
    - < BIT_MIN: abort.
    - < BIT_THR: shift in 0.
    - < SYNC_MIN: shift in 1.
    - >= SYNC_MIN: resync. Pulse frame_err, increment err_cnt, restart at GAP with bit_cnt=0. This counts as one error, not an abort to IDLE.
    - After a shift, bit_cnt increments. bit_cnt==72 goes to CHECK, otherwise to GAP.
  - CHECK (1 clk):
    - The checksum is valid if byte8 == 8'hA5 ^ b0 ^ b1 ^ ... ^ b7.
    - Valid: load park_frame, set park_vld, pulse frame_ok the next clk.
    - Invalid: abort.
    - Either way, go to IDLE.
- Abort: pulse frame_err, err_cnt += 1 (saturating at 255), go to IDLE. park_frame is unchanged.
- Bit order: MSB first within each byte, byte 0 first. The first received bit lands at park_frame[7].
- Latency: frame_ok asserts 2 clk after the rising edge of bit 72 becomes visible on line. park_frame is stable from the same edge as frame_ok.
- A new sync while in GAP cannot be detected until its rising edge. The pulse is classified in BIT_LOW as resync, per above.
- Reset mid-frame discards the partial frame. park_frame returns to 0 and park_vld to 0.
- frame_ok and frame_err are never asserted in the same clk.

Test Plan:
- Sync 1000 us, then bytes 01 02 03 04 05 06 07 08, checksum A5^08=AD, bits 100/200 us low and 100 us high gaps -> frame_ok once, park_frame = 72'hAD_08_07_06_05_04_03_02_01, park_vld=1, err_cnt=0.
- Same frame with checksum 00 -> frame_err once, err_cnt=1, park_frame keeps the previous value, park_vld unchanged.
- 30-bit valid prefix, then the line held high 600 us -> frame_err at GAP_MAX (500 us after the last rise), FSM in IDLE. A following good frame gives frame_ok.
- 20 us low glitch mid-frame -> abort with err_cnt+1. A 20-clk glitch (sub-tick, less than 1 us) while idle -> no state change and no error.
- 40 bits, then a 900 us low pulse, then a full good frame without a new leading sync -> frame_err once, then frame_ok with the new data.
- Force 300 aborted frames -> err_cnt saturates at 255. Assert rst_n low mid-frame -> all outputs 0 immediately (asynchronous).
